// File: rtl/bsg_fifo_1r1w_early.sv
// ---------------------------------------------------------------------------
// bsg_fifo_1r1w_early
//
// Small circular-buffer FIFO used as the backing store behind a FIFO-bypass
// stage. Every output is "early": ready_o, v_o and data_o come only from
// flops, so v_i and yumi_i are free to arrive late in the cycle. There is no
// internal bypass. A freshly written entry first appears on data_o in the
// cycle after it is written.
//
// Parameters:
//   width_p            data width in bits (>= 1)
//   els_p              number of entries (>= 2, need not be a power of two)
//   ready_THEN_valid_p 1: producer only raises v_i while ready_o=1
//                      0: v_i may be raised any time; enqueue is gated by ready_o
//
// Ports:
//   clk_i    in   rising-edge clock
//   reset_i  in   synchronous active-high reset; discards all contents
//   data_i   in   enqueue data (late)
//   v_i      in   enqueue valid (late)
//   ready_o  out  space available (registered)
//   data_o   out  head-of-queue data (flop array muxed by registered read pointer)
//   v_o      out  queue non-empty (registered)
//   yumi_i   in   dequeue the head this cycle (late); only legal while v_o=1
// ---------------------------------------------------------------------------
module bsg_fifo_1r1w_early #(
  parameter int width_p            = 8,
  parameter int els_p              = 4,
  parameter bit ready_THEN_valid_p = 1'b0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);
  localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);
  localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(els_p);

  // Reject illegal parameterisations at elaboration time.
  if (els_p < 2) begin : g_els_check
    $error("bsg_fifo_1r1w_early: els_p must be >= 2");
  end
  if (width_p < 1) begin : g_width_check
    $error("bsg_fifo_1r1w_early: width_p must be >= 1");
  end

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] rptr_q, rptr_d;
  logic [ptr_w_lp-1:0] wptr_q, wptr_d;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic                enq, deq;

  // Outputs come straight from flops so they never depend on late inputs.
  assign ready_o = ~full_q;
  assign v_o     = ~empty_q;
  assign data_o  = mem_q[rptr_q];

  // Next-state logic for pointers, occupancy and the registered full/empty
  // flags. Full/empty are derived from the next count so they can be
  // registered and presented early next cycle. Pointers wrap with an
  // explicit compare so non-power-of-two depths work.
  always_comb begin
    enq     = ready_THEN_valid_p ? v_i : (v_i & ready_o);
    deq     = yumi_i;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;

    if (enq) begin
      wptr_d = (wptr_q == last_ptr_lp) ? '0 : wptr_q + 1'b1;
    end
    if (deq) begin
      rptr_d = (rptr_q == last_ptr_lp) ? '0 : rptr_q + 1'b1;
    end

    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    full_d  = (count_d == full_cnt_lp);
    empty_d = (count_d == '0);
  end

  // Control state register. Reset empties the queue and ignores v_i/yumi_i.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage array is not reset; stale contents are hidden behind v_o=0.
  // A simultaneous write and read never hit the same entry because the
  // read side only ever sees entries written in earlier cycles.
  always_ff @(posedge clk_i) begin
    if (enq && !reset_i) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  // Simulation-only protocol checks on the late inputs.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(yumi_i && !v_o))
        else $error("bsg_fifo_1r1w_early: yumi_i asserted while v_o=0");
      if (ready_THEN_valid_p) begin
        assert (!(v_i && !ready_o))
          else $error("bsg_fifo_1r1w_early: v_i asserted while ready_o=0");
      end
    end
  end

endmodule

// File: tb/tb_bsg_fifo_1r1w_early.sv
// ---------------------------------------------------------------------------
// tb_bsg_fifo_1r1w_early
//
// Drives two FIFO instances (4 entries and 3 entries, 8-bit data). A plain
// queue per instance holds the expected contents: the stimulus side pushes
// whatever should be accepted, and an independent monitor compares data_o
// against the queue head whenever v_o is high, popping on yumi.
// ---------------------------------------------------------------------------
module tb_bsg_fifo_1r1w_early;

  localparam int W     = 8;
  localparam int DEPTH0 = 4;
  localparam int DEPTH1 = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] dataI0, dataI1, dataO0, dataO1;
  logic         vI0, vI1, yumiI0, yumiI1;
  logic         readyO0, readyO1, vO0, vO1;

  logic [W-1:0] expQ0[$];
  logic [W-1:0] expQ1[$];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  bsg_fifo_1r1w_early #(
    .width_p(W), .els_p(DEPTH0), .ready_THEN_valid_p(1'b0)
  ) dut0 (
    .clk_i(clk), .reset_i(reset), .data_i(dataI0), .v_i(vI0),
    .ready_o(readyO0), .data_o(dataO0), .v_o(vO0), .yumi_i(yumiI0)
  );

  bsg_fifo_1r1w_early #(
    .width_p(W), .els_p(DEPTH1), .ready_THEN_valid_p(1'b0)
  ) dut1 (
    .clk_i(clk), .reset_i(reset), .data_i(dataI1), .v_i(vI1),
    .ready_o(readyO1), .data_o(dataO1), .v_o(vO1), .yumi_i(yumiI1)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Checks the flag outputs against the reference occupancy, then drives one
  // cycle of inputs and records any entry the FIFO should accept.
  task automatic applyStimulus(input int d, input bit v, input logic [W-1:0] data, input bit yumi);
    int  depth  = (d == 0) ? DEPTH0 : DEPTH1;
    int  size   = (d == 0) ? expQ0.size() : expQ1.size();
    bit  doYumi = yumi && (size > 0);
    bit  doEnq  = v && (size < depth);
    if (d == 0) begin
      checkOutput("a_v_o", vO0, size > 0);
      checkOutput("a_ready_o", readyO0, size < depth);
      vI0 = v; dataI0 = data; yumiI0 = doYumi;
      if (doEnq) expQ0.push_back(data);
    end else begin
      checkOutput("b_v_o", vO1, size > 0);
      checkOutput("b_ready_o", readyO1, size < depth);
      vI1 = v; dataI1 = data; yumiI1 = doYumi;
      if (doEnq) expQ1.push_back(data);
    end
  endtask

  // One cycle on instance d while the other instance idles.
  task automatic step(input int d, input bit v, input logic [W-1:0] data, input bit yumi);
    @(negedge clk);
    applyStimulus(d, v, data, yumi);
    applyStimulus(1 - d, 1'b0, '0, 1'b0);
  endtask

  // Reset with v_i and yumi_i held high; nothing may be captured.
  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1;
    vI0 = 1'b1; yumiI0 = 1'b1; dataI0 = 8'hEE;
    vI1 = 1'b1; yumiI1 = 1'b1; dataI1 = 8'hEE;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    vI0 = 1'b0; yumiI0 = 1'b0;
    vI1 = 1'b0; yumiI1 = 1'b0;
    expQ0.delete();
    expQ1.delete();
    checkOutput("rst_a_v_o", vO0, 0);
    checkOutput("rst_a_ready_o", readyO0, 1);
    checkOutput("rst_b_v_o", vO1, 0);
    checkOutput("rst_b_ready_o", readyO1, 1);
  endtask

  // Monitor: a little after each falling edge the inputs for the coming
  // rising edge are settled. Whenever a FIFO presents data, compare it with
  // the reference head and consume the head if it is being dequeued.
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      if (vO0) begin
        if (expQ0.size() == 0) checkOutput("a_head_underflow", 1, 0);
        else begin
          checkOutput("a_head", dataO0, expQ0[0]);
          if (yumiI0) void'(expQ0.pop_front());
        end
      end
      if (vO1) begin
        if (expQ1.size() == 0) checkOutput("b_head_underflow", 1, 0);
        else begin
          checkOutput("b_head", dataO1, expQ1[0]);
          if (yumiI1) void'(expQ1.pop_front());
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    vI0 = 1'b0; yumiI0 = 1'b0; dataI0 = '0;
    vI1 = 1'b0; yumiI1 = 1'b0; dataI1 = '0;

    // Reset with handshakes held high.
    applyReset();
    step(0, 1'b0, '0, 1'b0);
    checkOutput("t1_no_write", vO0, 0);

    // Fill the 4-entry FIFO; head stays 0x11, ready drops after the 4th.
    step(0, 1'b1, 8'h11, 1'b0);
    step(0, 1'b1, 8'h22, 1'b0);
    step(0, 1'b1, 8'h33, 1'b0);
    step(0, 1'b1, 8'h44, 1'b0);
    step(0, 1'b0, '0, 1'b0);
    checkOutput("t2_full_ready", readyO0, 0);

    // Full with v_i and yumi_i together: only the dequeue happens.
    step(0, 1'b1, 8'h99, 1'b1);
    step(0, 1'b0, '0, 1'b0);
    checkOutput("t3_ready_back", readyO0, 1);
    checkOutput("t3_new_head", dataO0, 8'h22);

    // Drain, then single entry with simultaneous enqueue and dequeue.
    repeat (3) step(0, 1'b0, '0, 1'b1);
    step(0, 1'b1, 8'hA5, 1'b0);
    step(0, 1'b1, 8'h5A, 1'b1);
    step(0, 1'b0, '0, 1'b0);
    checkOutput("t4_v_o", vO0, 1);
    checkOutput("t4_head", dataO0, 8'h5A);
    step(0, 1'b0, '0, 1'b1);
    step(0, 1'b0, '0, 1'b0);
    checkOutput("t4_count_one", vO0, 0);

    // 3-entry FIFO: continuous push/pop of 0..9 wraps pointers 2->0.
    for (int i = 0; i < 10; i++) step(1, 1'b1, W'(i), 1'b1);
    step(1, 1'b0, '0, 1'b1);
    step(1, 1'b0, '0, 1'b0);
    checkOutput("t5_drained", vO1, 0);

    // Random traffic on both FIFOs at once.
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      applyStimulus(0, $urandom_range(0, 9) < 6, W'($urandom), $urandom_range(0, 9) < 5);
      applyStimulus(1, $urandom_range(0, 9) < 5, W'($urandom), $urandom_range(0, 9) < 6);
    end

    // Mid-operation reset must discard everything.
    applyReset();
    step(0, 1'b0, '0, 1'b0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
